// File: rtl/wr_addr_decoder_pkg.sv
// Shared datapath constants and the register-number one-hot helper used by
// both the writeback enable decoder and the register file read-side decoder.
package wr_addr_decoder_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Register 0 is hardwired to zero in the register file.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Register number to one-hot select vector.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wr_addr_decoder_onehot_dec.sv
// Combinational ADDR_W-to-2^ADDR_W enable decoder: the n-bit generalisation
// of the 1:2 enable decoder. vec is all zeros whenever en is low.
module onehot_dec
  import wr_addr_decoder_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] vec
);

  localparam int NUM_OUT = 1 << ADDR_W;

  generate
    if (ADDR_W == REG_ADDR_W) begin : g_regfile_width
      // Register-file width: share the package helper with the read side.
      assign vec = en ? onehot(addr) : '0;
    end else begin : g_generic_width
      // Any other width: compare the address against every output index.
      always_comb begin
        vec = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
          vec[k] = en && (addr == ADDR_W'(k));
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wr_addr_decoder.sv
// Registered writeback write-enable decoder. One pipeline register holds the
// one-hot enable, valid and address; stall freezes it. Writes to register 0
// can be suppressed and are counted in a saturating counter. hazard flags an
// incoming write to the register currently being written, for forwarding.
//
// Handshake: in_valid marks a write request in the cycle it is high; there is
// no ready. A request is taken on any rising edge with stall low, otherwise it
// is ignored. out_valid marks en_out/out_addr as a live write and is held, not
// re-issued, while stall is high.
module wr_addr_decoder
  import wr_addr_decoder_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter bit ZERO_PROTECT = 1'b1,
  parameter int CNT_W        = 8,
  localparam int NUM_OUT     = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic               stall,
  output logic [NUM_OUT-1:0] en_out,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               hazard,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [NUM_OUT-1:0] en_q, en_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               kill;
  logic               accept;
  logic [NUM_OUT-1:0] dec_vec;

  assign kill   = ZERO_PROTECT && (in_addr == ADDR_W'(ZERO_REG));
  assign accept = in_valid && !kill;

  onehot_dec #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr (in_addr),
    .en   (accept),
    .vec  (dec_vec)
  );

  // Next state: load on an unstalled edge, otherwise hold everything.
  always_comb begin
    en_d    = en_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      en_d    = dec_vec;
      valid_d = accept;
      addr_d  = in_addr;
      if (in_valid && kill && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pipeline register and drop counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      en_q    <= en_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en_out    = en_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign drop_cnt  = cnt_q;

  // Same-register hazard against the write currently on the outputs.
  assign hazard = in_valid && valid_q && (in_addr == addr_q);

endmodule

// File: tb/tb_wr_addr_decoder.sv
// Bench for wr_addr_decoder. Five instances with different parameters share
// one stimulus stream; a reference model computes expected outputs per
// instance from the decoding rules, and a monitor compares every cycle.
module tb_wr_addr_decoder;

  localparam int N  = 5;
  localparam int SW = 47;   // {hazard, valid, addr[4:0], en[31:0], drop[7:0]}
  localparam int W  = N * SW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [4:0] in_addr  = '0;
  logic       stall    = 1'b0;

  // ---------------- DUT instances ----------------
  // 0: ADDR_W=5 protect CNT_W=8   1: ADDR_W=5 no protect
  // 2: ADDR_W=2 no protect        3: ADDR_W=1 no protect
  // 4: ADDR_W=5 protect CNT_W=2
  logic [31:0] en0, en1, en4;
  logic [3:0]  en2;
  logic [1:0]  en3;
  logic        v0, v1, v2, v3, v4;
  logic        h0, h1, h2, h3, h4;
  logic [4:0]  a0, a1, a4;
  logic [1:0]  a2;
  logic [0:0]  a3;
  logic [7:0]  d0, d1, d2, d3;
  logic [1:0]  d4;

  wr_addr_decoder #(.ADDR_W(5), .ZERO_PROTECT(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .stall(stall),
    .en_out(en0), .out_valid(v0), .out_addr(a0), .hazard(h0), .drop_cnt(d0));
  wr_addr_decoder #(.ADDR_W(5), .ZERO_PROTECT(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .stall(stall),
    .en_out(en1), .out_valid(v1), .out_addr(a1), .hazard(h1), .drop_cnt(d1));
  wr_addr_decoder #(.ADDR_W(2), .ZERO_PROTECT(1'b0), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr[1:0]), .stall(stall),
    .en_out(en2), .out_valid(v2), .out_addr(a2), .hazard(h2), .drop_cnt(d2));
  wr_addr_decoder #(.ADDR_W(1), .ZERO_PROTECT(1'b0), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr[0:0]), .stall(stall),
    .en_out(en3), .out_valid(v3), .out_addr(a3), .hazard(h3), .drop_cnt(d3));
  wr_addr_decoder #(.ADDR_W(5), .ZERO_PROTECT(1'b1), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .stall(stall),
    .en_out(en4), .out_valid(v4), .out_addr(a4), .hazard(h4), .drop_cnt(d4));

  function automatic logic [SW-1:0] pack(logic hz, logic v, logic [4:0] a,
                                         logic [31:0] en, logic [7:0] d);
    return {hz, v, a, en, d};
  endfunction

  logic [SW-1:0] act [N];
  always_comb begin
    act[0] = pack(h0, v0, a0, en0, d0);
    act[1] = pack(h1, v1, a1, en1, d1);
    act[2] = pack(h2, v2, 5'(a2), 32'(en2), d2);
    act[3] = pack(h3, v3, 5'(a3), 32'(en3), d3);
    act[4] = pack(h4, v4, a4, en4, 8'(d4));
  end

  // ---------------- reference model ----------------
  int aw [N] = '{5, 5, 2, 1, 5};
  bit zp [N] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int cw [N] = '{8, 8, 8, 8, 2};

  bit mv [N];   // a live write is on the outputs
  int ma [N];   // register number on the outputs
  int md [N];   // suppressed r0 writes so far (saturating)

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      ma[i] = 0;
      md[i] = 0;
    end
  endtask

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_step();
    int  a;
    bit  k;
    if (!stall) begin
      for (int i = 0; i < N; i++) begin
        a     = int'(in_addr) % (1 << aw[i]);
        k     = zp[i] && (a == 0);
        mv[i] = in_valid && !k;
        ma[i] = a;
        if (in_valid && k && md[i] < (1 << cw[i]) - 1) md[i] = md[i] + 1;
      end
    end
  endtask

  function automatic logic [SW-1:0] expect_snap(int i);
    logic        hz;
    logic [31:0] en;
    hz = in_valid && mv[i] && ((int'(in_addr) % (1 << aw[i])) == ma[i]);
    en = mv[i] ? (32'd1 << ma[i]) : 32'd0;
    return pack(hz, mv[i], 5'(ma[i]), en, 8'(md[i]));
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: one expected snapshot per cycle, compared on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [SW-1:0] x;
    logic [SW-1:0] g;
    logic [31:0]   en;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < N; i++) begin
        x = e[i*SW +: SW];
        g = act[i];
        n_checks++;
        if (g !== x) begin
          n_fail++;
          $display("FAIL snapshot dut%0d t=%0t: got hz=%b v=%b a=%0d en=%h d=%0d, want hz=%b v=%b a=%0d en=%h d=%0d",
                   i, $time, g[46], g[45], g[44:40], g[39:8], g[7:0],
                   x[46], x[45], x[44:40], x[39:8], x[7:0]);
        end
        en = g[39:8];
        n_checks++;
        if (!($onehot0(en) && ((en != 0) == g[45]) && (!g[45] || en[g[44:40]]))) begin
          n_fail++;
          $display("FAIL invariant dut%0d t=%0t: got v=%b a=%0d en=%h, want one-hot en matching v and a",
                   i, $time, g[45], g[44:40], en);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [4:0] a, input logic s);
    logic [W-1:0] ent;
    in_valid = v;
    in_addr  = a;
    stall    = s;
    ent      = '0;
    for (int i = 0; i < N; i++) ent[i*SW +: SW] = expect_snap(i);
    exp_q.push_back(ent);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (act[i] !== '0) begin
        n_fail++;
        $display("FAIL %s dut%0d: got v=%b a=%0d en=%h d=%0d hz=%b, want all zero",
                 name, i, act[i][45], act[i][44:40], act[i][39:8], act[i][7:0], act[i][46]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Suppressed r0 writes, then a live write, then reset between edges.
    repeat (3) cycle(1'b1, 5'd0, 1'b0);
    repeat (3) cycle(1'b1, 5'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    in_valid = 1'b0;
    in_addr  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Five r0 writes: saturates the 2-bit counter.
    repeat (5) cycle(1'b1, 5'd0, 1'b0);

    // Full address sweep on consecutive cycles.
    for (int a = 0; a < 32; a++) cycle(1'b1, 5'(a), 1'b0);
    cycle(1'b0, 5'd1, 1'b0);
    cycle(1'b1, 5'd1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);

    // Stall hold, then release.
    cycle(1'b1, 5'd9, 1'b0);
    repeat (4) cycle(1'b1, 5'd12, 1'b1);
    cycle(1'b1, 5'd12, 1'b0);
    cycle(1'b0, 5'd0, 1'b0);

    // Hazard cases.
    cycle(1'b1, 5'd9, 1'b0);
    cycle(1'b1, 5'd9, 1'b0);
    cycle(1'b1, 5'd10, 1'b0);
    cycle(1'b0, 5'd10, 1'b0);
    cycle(1'b1, 5'd0, 1'b0);
    cycle(1'b1, 5'd0, 1'b0);

    // Bubble.
    cycle(1'b0, 5'd15, 1'b0);
    cycle(1'b0, 5'd15, 1'b0);

    // Randomised traffic with frequent r0 writes, stalls and repeats.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = in_addr;
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 3) == 0));
    end

    cycle(1'b0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
